mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's 4:1 one-bit mux between four requesters.
- Drives the mux select `sel` and a one-hot `grant`.
- Bounds each tenure with a hold-cycle limit, so one requester cannot starve the others.
- Sits between the requester logic and the mux; the mux itself stays purely combinational.

---
 rtl/mux_rr_arbiter_if.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output valid,
        output timeout
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux.
// Tenures are bounded by HOLD_CYCLES; all outputs are registered.
module mux_rr_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       gnt;
    logic [1:0]       sel_idx;
    logic             active;
    logic             tmo;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;

    // Search starts just after the last winner, so the holder scans last.
    always_comb begin
        found = 1'b0;
        win   = last;
        idx   = last;
        for (int k = 0; k < 4; k++) begin
            idx = last + 2'(k + 1);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Arbitration FSM with registered grant, select, valid and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd3;
            cnt     <= '0;
            gnt     <= 4'b0000;
            sel_idx <= 2'd0;
            active  <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            tmo <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt     <= 4'b0001 << win;
                        sel_idx <= win;
                        active  <= 1'b1;
                        last    <= win;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[last]) begin
                        if (found) begin
                            gnt     <= 4'b0001 << win;
                            sel_idx <= win;
                            last    <= win;
                            cnt     <= '0;
                        end else begin
                            gnt    <= 4'b0000;
                            active <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // holder still requesting: found is always set here
                        gnt     <= 4'b0001 << win;
                        sel_idx <= win;
                        last    <= win;
                        cnt     <= '0;
                        tmo     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant   = gnt;
    assign bus.sel     = sel_idx;
    assign bus.valid   = active;
    assign bus.timeout = tmo;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// checked against a tenure-level reference model plus literal checks.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    mux_rr_arbiter_if bus0 ();
    mux_rr_arbiter_if bus1 ();

    mux_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    mux_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: who holds, for how many cycles, who won last
    int hold_of [2];
    int m_holder[2];
    int m_ten   [2];
    int m_last  [2];
    int m_sel   [2];
    bit m_tmo   [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_holder[d] = -1;
            m_ten[d]    = 0;
            m_last[d]   = 3;
            m_sel[d]    = 0;
            m_tmo[d]    = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        int  w;
        int  c;
        bit  keeps;
        c     = m_holder[d];
        keeps = (c >= 0) && r[c];
        if (keeps && m_ten[d] < hold_of[d]) begin
            m_ten[d] = m_ten[d] + 1;
            m_tmo[d] = 1'b0;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && r[(m_last[d] + k) % 4])
                    w = (m_last[d] + k) % 4;
            end
            if (w >= 0) begin
                m_holder[d] = w;
                m_last[d]   = w;
                m_sel[d]    = w;
                m_ten[d]    = 1;
                m_tmo[d]    = keeps;
            end else begin
                m_holder[d] = -1;
                m_ten[d]    = 0;
                m_tmo[d]    = 1'b0;
            end
        end
    endtask

    task automatic set_req(input logic [3:0] v);
        bus0.req = v;
        bus1.req = v;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pack0();
        return {bus0.grant, bus0.sel, bus0.valid, bus0.timeout};
    endfunction

    function automatic logic [7:0] pack1();
        return {bus1.grant, bus1.sel, bus1.valid, bus1.timeout};
    endfunction

    function automatic logic [7:0] lit(input logic [3:0] g, input logic t);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) s = 2'(i);
        return {g, s, |g, t};
    endfunction

    // model advances on every edge; async reset clears it immediately
    initial begin
        hold_of[0] = 4;
        hold_of[1] = 1;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else for (int d = 0; d < 2; d++) model_step(d, bus0.req);
        end
    end

    // per-cycle comparison of both instances against the model
    initial begin
        logic [7:0] exp;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp = {(m_holder[d] >= 0) ? 4'(1 << m_holder[d]) : 4'b0000,
                       2'(m_sel[d]), m_holder[d] >= 0, m_tmo[d]};
                act = (d == 0) ? pack0() : pack1();
                n_cmp++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL model_d%0d t=%0t: got g=%b s=%0d v=%b t=%b required g=%b s=%0d v=%b t=%b",
                             d, $time, act[7:4], act[3:2], act[1], act[0],
                             exp[7:4], exp[3:2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] g;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        set_req(4'b0000);
        repeat (2) @(negedge clk);
        chk("reset_state", pack0(), 8'h00);
        rst = 1'b0;

        // single requester 2
        @(negedge clk);
        set_req(4'b0100);
        @(negedge clk);
        chk("single_c1", pack0(), lit(4'b0100, 1'b0));
        @(negedge clk);
        chk("single_c2", pack0(), lit(4'b0100, 1'b0));
        @(negedge clk);
        chk("single_c3", pack0(), lit(4'b0100, 1'b0));
        set_req(4'b0000);
        @(negedge clk);
        chk("single_rel", pack0(), {4'b0000, 2'd2, 1'b0, 1'b0});

        // async reset during contention, then full rotation
        set_req(4'b1111);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", pack0(), 8'h00);
        chk("async_rst_h1", pack1(), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            g = 4'(1 << ((k / 4) % 4));
            chk("rot_h4", pack0(), lit(g, (k % 4 == 0) && k > 0));
            g = 4'(1 << (k % 4));
            chk("rot_h1", pack1(), lit(g, k > 0));
        end
        set_req(4'b0000);
        @(negedge clk);
        chk("rot_idle", pack0() & 8'hf3, 8'h00);

        // sole requester past the hold limit
        set_req(4'b0001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("sole_h4", pack0(), lit(4'b0001, k == 4 || k == 8));
            chk("sole_h1", pack1(), lit(4'b0001, k > 0));
        end
        set_req(4'b0000);
        @(negedge clk);

        // fairness: 3 comes before 1 once 1 was last
        set_req(4'b0010);
        @(negedge clk);
        chk("fair_1", pack0(), lit(4'b0010, 1'b0));
        set_req(4'b0000);
        @(negedge clk);
        set_req(4'b1010);
        @(negedge clk);
        chk("fair_3", pack0(), lit(4'b1000, 1'b0));
        set_req(4'b0010);
        @(negedge clk);
        chk("fair_back", pack0(), lit(4'b0010, 1'b0));
        set_req(4'b0000);
        @(negedge clk);

        // reset mid-tenure with holder 2
        set_req(4'b0100);
        @(negedge clk);
        chk("mid_grant", pack0(), lit(4'b0100, 1'b0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("mid_rst", pack0(), 8'h00);
        set_req(4'b0110);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after", pack0(), lit(4'b0010, 1'b0));
        set_req(4'b0000);

        // random traffic with occasional async reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 3)
                set_req(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 249) == 0) begin
                #2 rst = 1'b1;
                #1 chk("rnd_rst", pack0(), 8'h00);
                #1 rst = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
